// File: rtl/cmsdk_uart_capture_mc.sv
// Multi-channel 8N1 UART capture for the MCU testbench: per-channel receivers and line printers,
// plus an ESC-prefixed control decoder on channel 0 (debug enable, AUXCTRL, end of simulation).
//
//   rx state | meaning
//   S_IDLE   | line idle, waiting for synchronised RXD low
//   S_START  | timing half a bit to re-check the start bit
//   S_DATA   | sampling 8 data bits, LSB first, one per BAUD_DIV
//   S_STOP   | sampling the stop bit
//
//   cmd state | meaning
//   C_IDLE    | channel-0 bytes go to the line buffer; 0x1B escapes
//   C_ESC     | previous byte was 0x1B; next byte is a command
//   C_AUX     | next byte is loaded into AUXCTRL
module cmsdk_uart_capture_mc #(
  parameter int NCH         = 2,
  parameter int BAUD_DIV    = 16,
  parameter int LINE_DEPTH  = 80,
  parameter int STOP_ON_END = 1
) (
  input  logic                 CLK,
  input  logic                 RESETn,
  input  logic [NCH-1:0]       RXD,
  output logic [NCH-1:0]       RX_VALID,
  output logic [8*NCH-1:0]     RX_DATA,
  output logic [NCH-1:0]       FRAME_ERR,
  output logic                 DEBUG_TESTER_ENABLE,
  output logic [7:0]           AUXCTRL,
  output logic                 SIMULATIONEND
);

  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] CNT_FULL = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(BAUD_DIV / 2 - 1);
  localparam int LW = $clog2(LINE_DEPTH + 1);
  localparam int AW = (LINE_DEPTH > 1) ? $clog2(LINE_DEPTH) : 1;
  localparam logic [LW-1:0] LEN_FULL = LW'(LINE_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} rx_state_t;
  typedef enum logic [1:0] {C_IDLE, C_ESC, C_AUX} cmd_state_t;

  logic [NCH-1:0] byte_ok;
  logic [7:0]     rx_byte [NCH];
  logic [NCH-1:0] consumed;
  logic           end_flush_req;

  cmd_state_t cmd_q, cmd_d;
  logic       dte_d;
  logic [7:0] aux_d;
  logic       end_d;

  always_comb begin
    cmd_d         = cmd_q;
    dte_d         = DEBUG_TESTER_ENABLE;
    aux_d         = AUXCTRL;
    end_d         = SIMULATIONEND;
    consumed      = '0;
    end_flush_req = 1'b0;
    if (byte_ok[0]) begin
      consumed[0] = (cmd_q != C_IDLE) || (rx_byte[0] == 8'h1B);
      case (cmd_q)
        C_IDLE: if (rx_byte[0] == 8'h1B) cmd_d = C_ESC;
        C_ESC: begin
          cmd_d = C_IDLE;
          case (rx_byte[0])
            8'h11: dte_d = 1'b1;
            8'h12: dte_d = 1'b0;
            8'h04: begin
              end_d         = 1'b1;
              end_flush_req = 1'b1;
            end
            8'h10: cmd_d = C_AUX;
            8'h1B: cmd_d = C_ESC;
            default: ;
          endcase
        end
        C_AUX: begin
          aux_d = rx_byte[0];
          cmd_d = C_IDLE;
        end
        default: cmd_d = C_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      cmd_q               <= C_IDLE;
      DEBUG_TESTER_ENABLE <= 1'b0;
      AUXCTRL             <= 8'h00;
      SIMULATIONEND       <= 1'b0;
    end else begin
      cmd_q               <= cmd_d;
      DEBUG_TESTER_ENABLE <= dte_d;
      AUXCTRL             <= aux_d;
      SIMULATIONEND       <= end_d;
    end
  end

  for (genvar n = 0; n < NCH; n++) begin : g_ch
    logic            sync1, sync2;
    rx_state_t       st_q, st_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      sh_q, sh_d;
    logic            ok_d, err_d;
    logic            valid_q, ferr_q;
    logic [7:0]      data_q;

    always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
        sync1 <= 1'b1;
        sync2 <= 1'b1;
      end else begin
        sync1 <= RXD[n];
        sync2 <= sync1;
      end
    end

    always_comb begin
      st_d  = st_q;
      cnt_d = cnt_q + 1'b1;
      bit_d = bit_q;
      sh_d  = sh_q;
      ok_d  = 1'b0;
      err_d = 1'b0;
      case (st_q)
        S_IDLE: begin
          cnt_d = '0;
          if (!sync2) st_d = S_START;
        end
        S_START: if (cnt_q == CNT_HALF) begin
          cnt_d = '0;
          bit_d = '0;
          st_d  = sync2 ? S_IDLE : S_DATA;
        end
        S_DATA: if (cnt_q == CNT_FULL) begin
          cnt_d = '0;
          sh_d  = {sync2, sh_q[7:1]};
          bit_d = bit_q + 1'b1;
          if (bit_q == 3'd7) st_d = S_STOP;
        end
        S_STOP: if (cnt_q == CNT_FULL) begin
          cnt_d = '0;
          st_d  = S_IDLE;
          ok_d  = sync2;
          err_d = ~sync2;
        end
        default: st_d = S_IDLE;
      endcase
    end

    always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
        st_q    <= S_IDLE;
        cnt_q   <= '0;
        bit_q   <= '0;
        sh_q    <= '0;
        valid_q <= 1'b0;
        ferr_q  <= 1'b0;
        data_q  <= '0;
      end else begin
        st_q    <= st_d;
        cnt_q   <= cnt_d;
        bit_q   <= bit_d;
        sh_q    <= sh_d;
        valid_q <= ok_d;
        ferr_q  <= err_d;
        if (ok_d) data_q <= sh_q;
      end
    end

    assign byte_ok[n]         = ok_d;
    assign rx_byte[n]         = sh_q;
    assign RX_VALID[n]        = valid_q;
    assign FRAME_ERR[n]       = ferr_q;
    assign RX_DATA[8*n +: 8]  = data_q;

    // Line buffer: text storage needs no reset, only the length does.
    logic [7:0]    line_mem [LINE_DEPTH];
    logic [LW-1:0] len_q;
    logic          to_buf, is_nl, is_chr, flush_full, flush_end;

    always_comb begin
      to_buf     = ok_d && !consumed[n];
      is_nl      = to_buf && (sh_q == 8'h0A);
      is_chr     = to_buf && (sh_q != 8'h0A) && (sh_q != 8'h0D);
      flush_full = is_chr && (len_q == LEN_FULL);
    end

    if (n == 0) begin : g_end
      assign flush_end = end_flush_req && (len_q != '0);
    end else begin : g_noend
      assign flush_end = 1'b0;
    end

    always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn)                len_q <= '0;
      else if (is_nl || flush_end) len_q <= '0;
      else if (is_chr)            len_q <= flush_full ? LW'(1) : len_q + 1'b1;
    end

    always_ff @(posedge CLK) begin
      if (is_chr) line_mem[flush_full ? AW'(0) : len_q[AW-1:0]] <= sh_q;
    end

`ifndef SYNTHESIS
    function automatic string line_text();
      string s = "";
      for (int i = 0; i < LINE_DEPTH; i++)
        if (i < int'(len_q)) s = $sformatf("%s%c", s, line_mem[i]);
      return s;
    endfunction

    always @(posedge CLK)
      if (RESETn && (is_nl || flush_full || flush_end))
        $display("UART%0d: %s", n, line_text());
`endif
  end

`ifndef SYNTHESIS
  logic [1:0] end_pipe;
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) end_pipe <= '0;
    else         end_pipe <= {end_pipe[0], SIMULATIONEND};
  end

  always @(posedge CLK)
    if (STOP_ON_END != 0 && RESETn && end_pipe[0] && !end_pipe[1]) $finish;
`endif

endmodule
